upower_fetch_unit: RTL and testbench
====================================

Name: upower_fetch_unit

Overview:
Instruction-fetch stage of the uPower datapath, directly upstream of the instruction memory. Holds the program counter and drives the memory word address. Captures the returned 32-bit instruction into an IF/ID output register that the decoder consumes over a valid/ready handshake. Supports branch redirect with flush, back-pressure stall, end-of-program detection, and an out-of-range fault.

Parameters:
PC_WIDTH, 32, width of the PC and all address ports; the PC is a word index, not a byte address.
NUM_INSTR, 6, number of instruction words in program memory; must be at least 1.
RESET_PC, 0, PC value after reset; must be less than NUM_INSTR.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
imem_addr  out  PC_WIDTH  word index to the instruction memory; equal to the PC register.
imem_data  in  32  instruction word from memory; combinational function of imem_addr in the same cycle.
redirect_valid  in  1  taken branch or jump this cycle.
redirect_target  in  PC_WIDTH  word index of the branch target.
if_valid  out  1  if_instr and if_pc hold an instruction for decode.
if_ready  in  1  decoder accepts the held instruction this cycle.
if_instr  out  32  fetched instruction.
if_pc  out  PC_WIDTH  word index of if_instr.
done  out  1  program exhausted and output register drained.
fault  out  1  sticky; a redirect target was at or above NUM_INSTR.

Behaviour:
- States are RUN, DONE and FAULT, held in a 2-bit state register.
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, state = RUN.
  - if_valid = 0, if_instr = 0, if_pc = 0.
  - done = 0, fault = 0.
- imem_addr = pc combinationally at all times, including during reset.
- accept = !if_valid || if_ready.
- RUN, no redirect, accept = 1:
  - if_instr <= imem_data, if_pc <= pc, if_valid <= 1.
  - pc <= pc + 1.
  - If pc + 1 == NUM_INSTR, state <= DONE. The PC never wraps.
- RUN, no redirect, accept = 0 (stall):
  - pc, if_instr, if_pc and if_valid hold.
  - Outputs stay stable for as long as if_valid = 1 and if_ready = 0.
- DONE:
  - No new captures.
  - if_ready with if_valid drains the register: if_valid <= 0.
  - done = (state == DONE) && !if_valid. It is a registered state combined with if_valid, with no combinational path from if_ready.
- Redirect has highest priority in RUN and DONE, and overrides capture and stall in the same cycle:
  - if_valid <= 0, which flushes the held instruction. The decoder must not rely on a handshake completing in the redirect cycle.
  - If redirect_target < NUM_INSTR: pc <= redirect_target, state <= RUN (this also leaves DONE).
  - Otherwise: state <= FAULT, pc holds.
- FAULT:
  - Sticky until reset; redirect_valid is ignored.
  - if_valid stays 0; fault = 1; done = 0.
- Latency: the instruction at pc appears on if_instr with if_valid = 1 one cycle after pc is presented, with no bubbles at full throughput (if_ready = 1).
  - After a redirect, there is exactly one bubble cycle: the target is captured on the edge after the redirect edge.
- Width rules:
  - pc + 1 is computed at PC_WIDTH + 1 bits before the comparison with NUM_INSTR.
  - redirect_target is compared unsigned.

Decomposition:
- Shared package upower_pkg holds:
  - INSTR_WIDTH = 32 and the PC_WIDTH default.
  - The fetch_state_t enum (RUN, DONE, FAULT).
  - The uPower NOP encoding 0x60000000, for benches.
- No sub-module: the next-PC mux and output register are small.
- The instruction memory is instantiated beside this block, not inside it.

Test Plan:
1. Straight-line run: NUM_INSTR = 6, words 0x38200005, 0x38400003, 0x7C611214, 0x60000000, 0x90610000, 0x60000000; if_ready held at 1 → if_pc = 0..5 on consecutive cycles with the matching words; done = 1 on the cycle after if_pc = 5 is accepted.
2. Stall: drop if_ready for 3 cycles while if_pc = 2 → if_instr = 0x7C611214, if_pc = 2 and imem_addr = 3 held unchanged; resume gives if_pc = 3 next.
3. Redirect: redirect_valid with target 1 while if_pc = 4 → if_valid = 0 for one cycle, then if_pc = 1, 0x38400003.
4. Redirect out of DONE: after done = 1, redirect to 0 → done falls, state returns to RUN, if_pc = 0 after one bubble.
5. Fault: redirect target 6 → fault = 1, if_valid = 0; a later redirect to 0 is ignored; only rst_n low clears fault.
6. Asynchronous reset mid-stall with if_valid = 1 → if_valid, if_pc, done and fault go to 0 immediately, before the next edge; imem_addr = 0.

Source files
------------

// File: rtl/upower_pkg.sv
// Shared uPower datapath definitions: widths, fetch FSM states and the NOP encoding.
package upower_pkg;

    localparam int unsigned INSTR_WIDTH      = 32;
    localparam int unsigned PC_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DONE  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h6000_0000;

endpackage

// File: rtl/upower_fetch_unit.sv
// uPower instruction-fetch stage: PC register, next-PC selection and the IF/ID
// output register with valid/ready handshake, redirect flush and fault trapping.
module upower_fetch_unit
    import upower_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = PC_WIDTH_DEFAULT,
    parameter int unsigned NUM_INSTR = 6,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   done,
    output logic                   fault
);

    localparam int unsigned EXT_WIDTH = PC_WIDTH + 1;

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH:0]   pc_inc;
    logic                accept;
    logic                last_instr;
    logic                target_ok;

    // Extra bit on the increment so the end-of-program compare never aliases on wrap.
    assign pc_inc     = {1'b0, pc} + EXT_WIDTH'(1);
    assign last_instr = (pc_inc == EXT_WIDTH'(NUM_INSTR));
    assign target_ok  = ({1'b0, redirect_target} < EXT_WIDTH'(NUM_INSTR));
    assign accept     = !if_valid || if_ready;

    assign imem_addr = pc;
    assign done      = (state == DONE) && !if_valid;
    assign fault     = (state == FAULT);

    // Fetch FSM and IF/ID register; redirect outranks capture, stall and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= PC_WIDTH'(RESET_PC);
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (state == FAULT) begin
            if_valid <= 1'b0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if (target_ok) begin
                pc    <= redirect_target;
                state <= RUN;
            end else begin
                state <= FAULT;
            end
        end else if (state == RUN) begin
            if (accept) begin
                if_instr <= imem_data;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc_inc[PC_WIDTH-1:0];
                if (last_instr) begin
                    state <= DONE;
                end
            end
        end else if (state == DONE) begin
            if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
        end else begin
            // Unused encoding: trap rather than fetch from an unknown state.
            if_valid <= 1'b0;
            state    <= FAULT;
        end
    end

endmodule

// File: tb/tb_upower_fetch_unit.sv
// Directed bench for upower_fetch_unit with a six-word program memory model.
module tb_upower_fetch_unit;
    import upower_pkg::*;

    localparam int unsigned PW = 32;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [PW-1:0] redirect_target;
    logic          if_valid;
    logic          if_ready;
    logic [31:0]   if_instr;
    logic [PW-1:0] if_pc;
    logic          done;
    logic          fault;

    logic [31:0] mem [6];
    int n_checks;
    int n_fail;

    upower_fetch_unit #(
        .PC_WIDTH (PW),
        .NUM_INSTR(6),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .done           (done),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd6) ? mem[imem_addr[2:0]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem[0] = 32'h3820_0005;
        mem[1] = 32'h3840_0003;
        mem[2] = 32'h7C61_1214;
        mem[3] = NOP_INSTR;
        mem[4] = 32'h9061_0000;
        mem[5] = NOP_INSTR;

        rst_n           = 1'b0;
        if_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        #2;
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        tick();
        rst_n = 1'b1;

        // Straight-line run at full throughput.
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("run_pc%0d", i), if_pc, 32'(i));
            check($sformatf("run_instr%0d", i), if_instr, mem[i]);
            check($sformatf("run_valid%0d", i), 32'(if_valid), 32'd1);
            check($sformatf("run_done%0d", i), 32'(done), 32'd0);
        end
        tick();
        check("drain_valid", 32'(if_valid), 32'd0);
        check("drain_done", 32'(done), 32'd1);
        check("drain_addr", imem_addr, 32'd6);
        tick();
        check("done_hold", 32'(done), 32'd1);

        // Redirect out of DONE.
        redirect_valid  = 1'b1;
        redirect_target = 32'd0;
        tick();
        redirect_valid = 1'b0;
        check("rdone_done", 32'(done), 32'd0);
        check("rdone_bubble", 32'(if_valid), 32'd0);
        check("rdone_addr", imem_addr, 32'd0);
        tick();
        check("rdone_pc", if_pc, 32'd0);
        check("rdone_instr", if_instr, mem[0]);
        check("rdone_valid", 32'(if_valid), 32'd1);
        tick();
        tick();
        check("pre_stall_pc", if_pc, 32'd2);

        // Stall while if_pc = 2.
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_pc%0d", i), if_pc, 32'd2);
            check($sformatf("stall_instr%0d", i), if_instr, 32'h7C61_1214);
            check($sformatf("stall_addr%0d", i), imem_addr, 32'd3);
            check($sformatf("stall_valid%0d", i), 32'(if_valid), 32'd1);
        end
        if_ready = 1'b1;
        tick();
        check("resume_pc", if_pc, 32'd3);
        check("resume_instr", if_instr, NOP_INSTR);
        tick();
        check("pre_redir_pc", if_pc, 32'd4);

        // Redirect to 1 while if_pc = 4.
        redirect_valid  = 1'b1;
        redirect_target = 32'd1;
        tick();
        redirect_valid = 1'b0;
        check("redir_bubble", 32'(if_valid), 32'd0);
        check("redir_addr", imem_addr, 32'd1);
        tick();
        check("redir_pc", if_pc, 32'd1);
        check("redir_instr", if_instr, 32'h3840_0003);
        check("redir_valid", 32'(if_valid), 32'd1);

        // Out-of-range target traps; later redirects are ignored.
        redirect_valid  = 1'b1;
        redirect_target = 32'd6;
        tick();
        check("fault_set", 32'(fault), 32'd1);
        check("fault_valid", 32'(if_valid), 32'd0);
        check("fault_done", 32'(done), 32'd0);
        check("fault_addr", imem_addr, 32'd2);
        redirect_target = 32'd0;
        tick();
        redirect_valid = 1'b0;
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_ign_addr", imem_addr, 32'd2);
        check("fault_ign_valid", 32'(if_valid), 32'd0);
        tick();
        check("fault_hold", 32'(fault), 32'd1);

        // Reset clears fault, then async reset in the middle of a stall.
        rst_n = 1'b0;
        #1;
        check("fault_clear", 32'(fault), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("re_pc", if_pc, 32'd0);
        check("re_valid", 32'(if_valid), 32'd1);
        if_ready = 1'b0;
        tick();
        tick();
        check("re_stall_pc", if_pc, 32'd0);
        check("re_stall_addr", imem_addr, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(if_valid), 32'd0);
        check("arst_pc", if_pc, 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        check("arst_addr", imem_addr, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
